// File: rtl/word_packer.sv
// word_packer
//   Collects RATIO consecutive WIDTH-bit words from a registered-output FIFO
//   dequeue port into one RATIO*WIDTH-bit word (lane 0 = first word) and
//   presents it on a valid/ready output. in_data is sampled one cycle after
//   the accepting handshake. A partially filled word can be emitted on flush.
//
//   Optional build macro: WORD_PACKER_TIMEOUT_EN
//     When defined, a partial word idle for TIMEOUT cycles is flushed
//     automatically.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream word available (FIFO deq_valid)
//   in_ready   : packer accepts a word (drives FIFO deq_ready)
//   in_data    : word data, valid the cycle after the accepting handshake
//   flush      : single-cycle request to emit the partial word
//   out_valid  : packed word available
//   out_ready  : downstream accepts the packed word
//   out_data   : packed word
//   out_lanes  : number of populated lanes in out_data (1..RATIO)
//   busy       : partial word held, capture in flight or flush pending
module word_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RATIO*WIDTH-1:0]     out_data,
    output logic [$clog2(RATIO+1)-1:0] out_lanes,
    output logic                       busy
);

    localparam int IDXW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW   = $clog2(RATIO + 1);
    localparam int OW   = RATIO * WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(RATIO - 1);
    localparam logic            MULTI_LANE = (RATIO > 1) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_FILL       = 2'd1;
    localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

    logic [IDXW-1:0] idx_r;
    logic            cap_r;
    logic [IDXW-1:0] cap_lane_r;
    logic            flush_pend_r;
    logic [OW-1:0]   buf_r;
    logic [1:0]      state_r;
    logic            out_valid_r;
    logic [OW-1:0]   out_data_r;
    logic [LW-1:0]   out_lanes_r;

    logic            in_ready_s;
    logic            hs_s;
    logic            hs_last_s;
    logic            out_free_s;
    logic            full_emit_s;
    logic            part_emit_s;
    logic            flush_set_s;
    logic            flush_pend_next_s;
    logic [IDXW-1:0] idx_next_s;
    logic [1:0]      state_next_s;
    logic [OW-1:0]   merged_s;
    logic            timeout_hit_s;

    // Handshake, emit and flush decisions for the coming edge.
    always_comb begin
        // The last lane is only accepted once the output register is empty
        // and no earlier capture is outstanding, so a full-word capture can
        // always land straight into the output register.
        in_ready_s  = !flush_pend_r && !((idx_r == LAST_IDX) && (out_valid_r || cap_r));
        hs_s        = in_valid && in_ready_s;
        hs_last_s   = hs_s && (idx_r == LAST_IDX);
        out_free_s  = !out_valid_r || out_ready;
        full_emit_s = cap_r && (cap_lane_r == LAST_IDX);
        part_emit_s = flush_pend_r && !cap_r && out_free_s;
        // A flush needs at least one lane that is not part of a completing
        // word: a last-lane handshake (or idx already wrapped) means the
        // word emits in full anyway.
        flush_set_s = (flush || timeout_hit_s) && MULTI_LANE && !flush_pend_r &&
                      !hs_last_s && ((idx_r != {IDXW{1'b0}}) || hs_s);

        if (part_emit_s) begin
            idx_next_s = {IDXW{1'b0}};
        end else if (hs_last_s) begin
            idx_next_s = {IDXW{1'b0}};
        end else if (hs_s) begin
            idx_next_s = idx_r + IDXW'(1);
        end else begin
            idx_next_s = idx_r;
        end

        if (part_emit_s) begin
            flush_pend_next_s = 1'b0;
        end else if (flush_set_s) begin
            flush_pend_next_s = 1'b1;
        end else begin
            flush_pend_next_s = flush_pend_r;
        end

        if (flush_pend_next_s) begin
            state_next_s = ST_FLUSH_PEND;
        end else if ((idx_next_s != {IDXW{1'b0}}) || hs_s) begin
            state_next_s = ST_FILL;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Assembly buffer with the in-flight capture merged into its lane.
    always_comb begin
        merged_s = buf_r;
        for (int i = 0; i < RATIO; i++) begin
            if (cap_r && (cap_lane_r == IDXW'(i))) begin
                merged_s[i*WIDTH +: WIDTH] = in_data;
            end else begin
                merged_s[i*WIDTH +: WIDTH] = buf_r[i*WIDTH +: WIDTH];
            end
        end
    end

    // Lane index, capture tracking, assembly buffer and state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= {IDXW{1'b0}};
            cap_r        <= 1'b0;
            cap_lane_r   <= {IDXW{1'b0}};
            flush_pend_r <= 1'b0;
            buf_r        <= {OW{1'b0}};
            state_r      <= ST_IDLE;
        end else begin
            idx_r        <= idx_next_s;
            cap_r        <= hs_s;
            flush_pend_r <= flush_pend_next_s;
            state_r      <= state_next_s;
            if (hs_s) begin
                cap_lane_r <= idx_r;
            end
            if (full_emit_s || part_emit_s) begin
                buf_r <= {OW{1'b0}};
            end else if (cap_r) begin
                buf_r <= merged_s;
            end
        end
    end

    // Output register: loads full or partial words, drops on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OW{1'b0}};
            out_lanes_r <= {LW{1'b0}};
        end else if (full_emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= merged_s;
            out_lanes_r <= LW'(RATIO);
        end else if (part_emit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= buf_r;
            out_lanes_r <= LW'(idx_r);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef WORD_PACKER_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT + 1);
    logic [TMW-1:0] tmo_cnt_r;

    // Idle counter for auto-flush; holds at TIMEOUT until the flush lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TMW{1'b0}};
        end else if (hs_s || full_emit_s || part_emit_s) begin
            tmo_cnt_r <= {TMW{1'b0}};
        end else if ((state_r == ST_FILL) && !cap_r && (tmo_cnt_r != TMW'(TIMEOUT))) begin
            tmo_cnt_r <= tmo_cnt_r + TMW'(1);
        end
    end

    assign timeout_hit_s = (tmo_cnt_r == TMW'(TIMEOUT));
`else
    assign timeout_hit_s = 1'b0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_lanes = out_lanes_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
